// File: rtl/alu_pkg.sv
// Shared types for the ALU output stage: op-class codes and the buffered entry layout.
// The parity field exists only when ALU_OUT_PARITY_EN is defined.
package alu_pkg;

    localparam logic [1:0] OP_ARITH = 2'b00;
    localparam logic [1:0] OP_LOGIC = 2'b01;
    localparam logic [1:0] OP_CMP   = 2'b10;
    localparam logic [1:0] OP_SHIFT = 2'b11;

    // Operand width the entry layout is built for; the top refuses any other width.
    localparam int ALU_OPRND_WIDTH = 8;

    typedef struct packed {
        logic [1:0]                   op;
        logic                         flag;
        logic [2*ALU_OPRND_WIDTH-1:0] data;
`ifdef ALU_OUT_PARITY_EN
        logic                         parity;
`endif
    } alu_entry_t;

    // Even parity bit: XOR of the covered bits makes the total count of ones even.
    function automatic logic even_parity(input logic [1:0] op, input logic flag,
                                         input logic [2*ALU_OPRND_WIDTH-1:0] data);
        return ^{op, flag, data};
    endfunction

endpackage

// File: rtl/alu_out_fifo.sv
// Generic 2-entry synchronous FIFO with valid/ready on both sides.
// in_ready depends only on occupancy, so a full FIFO never passes data through.
module alu_out_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic                        wr_ptr;
    logic                        rd_ptr;
    logic [1:0]                  count;
    logic                        push;
    logic                        pop;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            // Push and pop together can only happen at count=1 and leave it unchanged.
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/alu_out_stage.sv
// Registered ALU output stage: priority-selects the enabled unit, zero-extends and tags it,
// buffers it in a 2-entry FIFO. Define ALU_OUT_PARITY_EN to add the Out_Parity port.
module alu_out_stage
    import alu_pkg::*;
#(
    parameter int OPRND_WIDTH = 8,
    parameter int DEPTH       = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Arith_Enable,
    input  logic                     Logic_Enable,
    input  logic                     CMP_Enable,
    input  logic                     Shift_Enable,
    input  logic [2*OPRND_WIDTH-1:0] Arith_Out,
    input  logic                     Arith_Carry,
    input  logic [OPRND_WIDTH-1:0]   Logic_Out,
    input  logic [OPRND_WIDTH-1:0]   CMP_Out,
    input  logic [OPRND_WIDTH-1:0]   Shift_Out,
    output logic                     In_Ready,
    output logic [2*OPRND_WIDTH-1:0] Out_Data,
    output logic [1:0]               Out_Op,
    output logic                     Out_Flag,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
`ifdef ALU_OUT_PARITY_EN
    output logic                     Out_Parity,
`endif
    output logic                     Multi_Hot_Err,
    output logic [CNT_WIDTH-1:0]     Result_Count
);

    if (OPRND_WIDTH != ALU_OPRND_WIDTH || DEPTH != 2) begin : g_bad_cfg
        $error("alu_out_stage: unsupported OPRND_WIDTH/DEPTH");
    end

    localparam logic [OPRND_WIDTH-1:0] ZEXT = '0;

    logic [3:0]  en;
    logic        any_en;
    logic        multi_hot;
    logic        pop;
    alu_entry_t  wr_entry;
    alu_entry_t  head;

    assign en        = {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable};
    assign any_en    = |en;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_hot = |(en & (en - 4'd1));

    always_comb begin
        wr_entry = '0;
        if (Arith_Enable) begin
            wr_entry.op   = OP_ARITH;
            wr_entry.flag = Arith_Carry;
            wr_entry.data = Arith_Out;
        end else if (Logic_Enable) begin
            wr_entry.op   = OP_LOGIC;
            wr_entry.data = {ZEXT, Logic_Out};
        end else if (CMP_Enable) begin
            wr_entry.op   = OP_CMP;
            wr_entry.data = {ZEXT, CMP_Out};
        end else if (Shift_Enable) begin
            wr_entry.op   = OP_SHIFT;
            wr_entry.data = {ZEXT, Shift_Out};
        end
`ifdef ALU_OUT_PARITY_EN
        wr_entry.parity = even_parity(wr_entry.op, wr_entry.flag, wr_entry.data);
`endif
    end

    alu_out_fifo #(
        .WIDTH ($bits(alu_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .in_valid  (any_en),
        .in_ready  (In_Ready),
        .in_data   (wr_entry),
        .out_valid (Out_Valid),
        .out_ready (Out_Ready),
        .out_data  (head)
    );

    assign Out_Data = head.data;
    assign Out_Op   = head.op;
    assign Out_Flag = head.flag;
`ifdef ALU_OUT_PARITY_EN
    assign Out_Parity = head.parity;
`endif

    assign pop = Out_Valid && Out_Ready;

    // Multi-hot is flagged whenever it is seen, accepted or not.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Multi_Hot_Err <= 1'b0;
            Result_Count  <= '0;
        end else begin
            if (multi_hot)
                Multi_Hot_Err <= 1'b1;
            if (pop)
                Result_Count <= Result_Count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_out_stage.sv
// Self-checking bench for alu_out_stage: directed scenarios plus random traffic against a queue model.
module tb_alu_out_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
    logic [15:0] Arith_Out;
    logic        Arith_Carry;
    logic [7:0]  Logic_Out, CMP_Out, Shift_Out;
    logic        In_Ready;
    logic [15:0] Out_Data;
    logic [1:0]  Out_Op;
    logic        Out_Flag;
    logic        Out_Valid;
    logic        Out_Ready;
    logic        Multi_Hot_Err;
    logic [7:0]  Result_Count;
`ifdef ALU_OUT_PARITY_EN
    logic        Out_Parity;
`endif

    always #5 CLK = ~CLK;

    alu_out_stage dut (
        .CLK(CLK), .RST(RST),
        .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
        .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
        .Arith_Out(Arith_Out), .Arith_Carry(Arith_Carry),
        .Logic_Out(Logic_Out), .CMP_Out(CMP_Out), .Shift_Out(Shift_Out),
        .In_Ready(In_Ready), .Out_Data(Out_Data), .Out_Op(Out_Op),
        .Out_Flag(Out_Flag), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
`ifdef ALU_OUT_PARITY_EN
        .Out_Parity(Out_Parity),
`endif
        .Multi_Hot_Err(Multi_Hot_Err), .Result_Count(Result_Count)
    );

    typedef struct { logic [1:0] op; logic flag; logic [15:0] data; } ent_t;

    ent_t q[$];
    logic m_err;
    int   m_cnt;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", {31'b0, In_Ready}, {31'b0, q.size() < 2});
        chk("out_valid", {31'b0, Out_Valid}, {31'b0, q.size() > 0});
        chk("multi_hot_err", {31'b0, Multi_Hot_Err}, {31'b0, m_err});
        chk("result_count", {24'b0, Result_Count}, m_cnt);
        if (q.size() > 0) begin
            chk("out_data", {16'b0, Out_Data}, {16'b0, q[0].data});
            chk("out_op", {30'b0, Out_Op}, {30'b0, q[0].op});
            chk("out_flag", {31'b0, Out_Flag}, {31'b0, q[0].flag});
`ifdef ALU_OUT_PARITY_EN
            chk("out_parity", {31'b0, Out_Parity},
                {31'b0, ^{q[0].op, q[0].flag, q[0].data}});
`endif
        end
    endtask

    // en = {arith, logic, cmp, shift}; applies inputs, advances the model one clock, checks.
    task automatic step(input logic [3:0] en, input logic [15:0] a, input logic c,
                        input logic [7:0] l, input logic [7:0] cm, input logic [7:0] s,
                        input logic ordy);
        bit   can_push;
        bit   do_pop;
        ent_t e;
        {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable} = en;
        Arith_Out = a; Arith_Carry = c; Logic_Out = l; CMP_Out = cm; Shift_Out = s;
        Out_Ready = ordy;
        can_push = q.size() < 2;
        do_pop   = (q.size() > 0) && ordy;
        if ($countones(en) > 1) m_err = 1'b1;
        if (do_pop) begin
            void'(q.pop_front());
            m_cnt = (m_cnt + 1) % 256;
        end
        if (en != 4'b0 && can_push) begin
            if (en[3])      e = '{2'b00, c, a};
            else if (en[2]) e = '{2'b01, 1'b0, {8'h00, l}};
            else if (en[1]) e = '{2'b10, 1'b0, {8'h00, cm}};
            else            e = '{2'b11, 1'b0, {8'h00, s}};
            q.push_back(e);
        end
        @(negedge CLK);
        check_all();
    endtask

    task automatic idle(input logic ordy);
        step(4'b0000, 16'h0, 1'b0, 8'h0, 8'h0, 8'h0, ordy);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable} = 4'b0;
        Arith_Out = '0; Arith_Carry = 1'b0; Logic_Out = '0; CMP_Out = '0; Shift_Out = '0;
        Out_Ready = 1'b0;
        q.delete(); m_err = 1'b0; m_cnt = 0;
        @(negedge CLK); @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_out_data", {16'b0, Out_Data}, 32'h0);
        chk("rst_out_op", {30'b0, Out_Op}, 32'h0);
        chk("rst_out_flag", {31'b0, Out_Flag}, 32'h0);
`ifdef ALU_OUT_PARITY_EN
        chk("rst_out_parity", {31'b0, Out_Parity}, 32'h0);
`endif
        check_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] en;
        do_reset();

        // Logic A5, then pop it
        step(4'b0100, 16'h0, 1'b0, 8'hA5, 8'h0, 8'h0, 1'b1);
        chk("plan_logic_data", {16'b0, Out_Data}, 32'h00A5);
        chk("plan_logic_op", {30'b0, Out_Op}, 32'h1);
        idle(1'b1);
        chk("plan_logic_count", {24'b0, Result_Count}, 32'h1);

        // Arith with carry
        step(4'b1000, 16'hFE01, 1'b1, 8'h0, 8'h0, 8'h0, 1'b1);
        chk("plan_arith_flag", {31'b0, Out_Flag}, 32'h1);
        idle(1'b1);

        // Stall: third push must be dropped
        step(4'b0010, 16'h0, 1'b0, 8'h0, 8'h01, 8'h0, 1'b0);
        step(4'b0001, 16'h0, 1'b0, 8'h0, 8'h0, 8'h80, 1'b0);
        chk("stall_in_ready", {31'b0, In_Ready}, 32'h0);
        step(4'b0100, 16'h0, 1'b0, 8'h0F, 8'h0, 8'h0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        idle(1'b1);
        chk("stall_second", {16'b0, Out_Data}, 32'h0080);
        idle(1'b1);
        chk("stall_empty", {31'b0, Out_Valid}, 32'h0);

        // Push and pop together at count=1
        step(4'b0010, 16'h0, 1'b0, 8'h0, 8'h11, 8'h0, 1'b0);
        step(4'b0100, 16'h0, 1'b0, 8'h22, 8'h0, 8'h0, 1'b1);
        chk("pushpop_ready", {31'b0, In_Ready}, 32'h1);
        chk("pushpop_data", {16'b0, Out_Data}, 32'h0022);
        idle(1'b1);

        // Multi-hot: arith wins, error sticks
        step(4'b1001, 16'h1234, 1'b0, 8'h0, 8'h0, 8'h55, 1'b0);
        chk("multihot_op", {30'b0, Out_Op}, 32'h0);
        for (int i = 0; i < 10; i++) idle(1'b0);
        chk("multihot_sticky", {31'b0, Multi_Hot_Err}, 32'h1);

        // Async reset with an entry pending
        #2 RST = 1'b1;
        #1;
        chk("async_valid_drop", {31'b0, Out_Valid}, 32'h0);
        chk("async_err_clear", {31'b0, Multi_Hot_Err}, 32'h0);
        do_reset();

        // 256 pops wrap the counter
        for (int i = 0; i < 256; i++)
            step(4'b0100, 16'h0, 1'b0, 8'($urandom), 8'h0, 8'h0, 1'b1);
        idle(1'b1);
        chk("count_wrap", {24'b0, Result_Count}, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0)      en = 4'($urandom);
            else if ($urandom_range(2) == 0) en = 4'b0000;
            else                             en = 4'b0001 << $urandom_range(3);
            step(en, 16'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_out_stage.md
Name: alu_out_stage

Overview:
- Registered output stage directly downstream of the ALU op decoder and its four execution units (arith, logic, compare, shift).
- Uses the decoder's one-hot enables to select the active unit's result. Zero-extends the result to a common width, tags it with its op class and buffers it in a 2-entry FIFO.
- Presents the buffered result to the consumer (register file write-back / UART TX formatter) over a valid/ready handshake, so downstream back-pressure never drops a result.

Parameters:
- OPRND_WIDTH, 8, operand width W of the logic, compare and shift units.
- DEPTH, 2, FIFO entries. Fixed at 2; any other value is unsupported.
- CNT_WIDTH, 8, width of the delivered-result counter.

Ports:
- CLK  in  1  stage clock.
- RST  in  1  asynchronous, active-high reset.
- Arith_Enable  in  1  decoder enable, arith unit result is valid this cycle.
- Logic_Enable  in  1  decoder enable, logic unit.
- CMP_Enable  in  1  decoder enable, compare unit.
- Shift_Enable  in  1  decoder enable, shift unit.
- Arith_Out  in  2W  arith result (mul-capable width).
- Arith_Carry  in  1  arith carry/overflow flag.
- Logic_Out  in  W  logic result.
- CMP_Out  in  W  compare result.
- Shift_Out  in  W  shift result.
- In_Ready  out  1  stage can accept a result this cycle.
- Out_Data  out  2W  head result.
- Out_Op  out  2  head op class: 00 arith, 01 logic, 10 cmp, 11 shift.
- Out_Flag  out  1  head flag.
- Out_Valid  out  1  head entry valid.
- Out_Ready  in  1  consumer accepts head.
- Multi_Hot_Err  out  1  sticky: more than one enable seen high in the same cycle.
- Result_Count  out  CNT_WIDTH  number of results delivered.

Behaviour:
- Reset (async assert, deasserted synchronously to CLK by the upstream reset sync):
  - FIFO count=0, read/write pointers=0.
  - Out_Valid=0, Out_Data=0, Out_Op=0, Out_Flag=0.
  - Multi_Hot_Err=0, Result_Count=0.
  - In_Ready=1 in the first cycle after reset.
- Push:
  - Push occurs when any enable is high and In_Ready=1.
  - In_Ready = (count < 2). It is combinational on count only and never depends on Out_Ready (no pass-through at full).
  - Enables arriving while In_Ready=0 are ignored. The upstream sequencer holds the op until In_Ready=1.
- Selection and width:
  - Priority Arith > Logic > CMP > Shift.
  - W-bit results are zero-extended to 2W.
  - Out_Op encodes the selected class.
  - Out_Flag = Arith_Carry for arith entries, 0 for all others.
- Multi-hot enables: if two or more enables are high in one cycle:
  - Multi_Hot_Err is set, and stays set until reset.
  - The highest-priority result is still pushed.
- Pop:
  - Out_Valid = (count > 0). Out_Data, Out_Op and Out_Flag come from the head entry.
  - Pop occurs when Out_Valid && Out_Ready.
  - Head fields stay stable while Out_Valid=1 and Out_Ready=0.
- Latency: a result pushed in cycle N appears with Out_Valid=1 in cycle N+1 at the earliest.
- Count update per cycle:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged. This is only possible at count=1.
  - Pointers wrap modulo 2.
- Result_Count increments on every pop and wraps from 2^CNT_WIDTH-1 to 0.
- Reset mid-transfer: FIFO contents are discarded, Out_Valid drops immediately (asynchronously), and nothing is replayed.

Optional Feature:
- Macro: ALU_OUT_PARITY_EN.
- With the macro defined:
  - Extra output port Out_Parity (1 bit) = even parity over {Out_Op, Out_Flag, Out_Data}.
  - Parity is computed at push and stored per entry.
  - Reset value of Out_Parity is 0.
- Without the macro: the port and its storage are absent. All other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - Op-class constants OP_ARITH=2'b00, OP_LOGIC=2'b01, OP_CMP=2'b10, OP_SHIFT=2'b11.
  - The FIFO entry struct {op, flag, data[, parity]}.
- One sub-module, alu_out_fifo: the generic 2-entry synchronous FIFO with valid/ready on both sides.
- The select/extend/priority logic and the sticky error stay in the top block.

Test Plan:
- Reset, then Logic_Enable=1 with Logic_Out=8'hA5 and Out_Ready=1 → next cycle Out_Valid=1, Out_Data=16'h00A5, Out_Op=01, Out_Flag=0, and Result_Count=1 after the pop.
- Arith_Enable=1 with Arith_Out=16'hFE01 and Arith_Carry=1 → Out_Data=16'hFE01, Out_Op=00, Out_Flag=1.
- Out_Ready=0, then push three ops (CMP 8'h01, Shift 8'h80, Logic 8'h0F) → In_Ready=0 after the second push and the third is not accepted. Raising Out_Ready then yields 0001 (op 10) followed by 0080 (op 11), with stable data while stalled.
- Count=1 with push and pop in the same cycle → count stays 1, FIFO order is preserved, no loss or duplication.
- Arith_Enable=1 and Shift_Enable=1 together → arith result pushed, Multi_Hot_Err=1 and still 1 after 10 clean cycles. Asserting RST clears it and Out_Valid drops at once.
- 256 consecutive pops → Result_Count wraps to 0. With ALU_OUT_PARITY_EN defined, Out_Parity matches a reference parity computed over every delivered entry.
